fc_mac_scheduler: RTL and testbench
===================================

Name: fc_mac_scheduler

Overview:
Sequencer that time-multiplexes one accumulating MAC unit across NUM_NEURONS output neurons of a fully connected layer. Each neuron is a dot product over VEC_LEN flattened inputs. The block generates input-buffer and weight-ROM addresses and issues one MAC operation per cycle. It counts returned MAC results and delivers one result per neuron on a valid/ready stream.

Parameters:
VEC_LEN, 225, dot-product length per neuron (inputs per neuron)
NUM_NEURONS, 10, number of output neurons sequenced per start
ACC_W, 48, signed accumulator/result width
MAC_LAT, 1, MAC input-to-output latency in cycles (informational for bench; scheduler does not depend on it)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
i_start  input  1  level; rising edge in IDLE launches a layer run
i_abort  input  1  synchronous abort, returns to IDLE
o_busy  output  1  high in any state except IDLE
o_done  output  1  one-cycle pulse after last neuron result accepted
o_in_addr  output  $clog2(VEC_LEN)  input-vector element index
o_w_addr  output  $clog2(VEC_LEN*NUM_NEURONS)  weight ROM address = neuron*VEC_LEN + k
o_mac_valid  output  1  MAC operand valid this cycle
o_mac_clear  output  1  with o_mac_valid: first term, MAC starts from zero
i_mac_valid  input  1  MAC result valid
i_mac_sum  input  ACC_W  signed MAC running sum
o_res_valid  output  1  neuron result valid
i_res_ready  input  1  downstream accepts result
o_res_data  output  ACC_W  signed neuron result
o_res_idx  output  $clog2(NUM_NEURONS)  neuron index of o_res_data

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, start edge register 0.
- States: IDLE, ISSUE, DRAIN, OUTPUT, DONE.
- IDLE: on rising edge of i_start (i_start & ~i_start_d1), clear neuron counter n and element counter k -> ISSUE. Start edges are ignored outside IDLE.
- ISSUE: o_mac_valid=1 every cycle. o_in_addr=k, o_w_addr=n*VEC_LEN+k. o_mac_clear=1 only when k==0. k increments each cycle. When k==VEC_LEN-1 issue, -> DRAIN; k resets.
- Return counter r increments on each i_mac_valid in ISSUE/DRAIN. On the VEC_LEN-th return, latch i_mac_sum into o_res_data, set o_res_idx=n -> OUTPUT. In DRAIN, o_mac_valid=0.
- OUTPUT: o_res_valid held with stable data until i_res_ready. On the handshake cycle, o_res_valid drops next cycle. If n==NUM_NEURONS-1 -> DONE, else n+1, r=0 -> ISSUE.
- DONE: o_done=1 for exactly one cycle -> IDLE.
- Neurons never overlap: the next neuron's issue starts only after the previous result is accepted (backpressure-safe, no result buffer).
- i_mac_valid in IDLE/OUTPUT/DONE is ignored; r is not incremented.
- i_abort has priority over everything in any state: next cycle IDLE, o_res_valid=0, o_mac_valid=0, no o_done. Stale MAC returns after abort are ignored.
- Async reset mid-run: immediate return to reset values. i_start held high through reset does not launch a run until it goes low then high.
- Address widths: o_w_addr computed combinationally from n and k, with no wrap inside a run. The max address is VEC_LEN*NUM_NEURONS-1.
- Best-case cycles per neuron: VEC_LEN + MAC_LAT + 1 (handshake).

Optional Feature:
FC_RELU_EN. When defined, the latched result is clamped to 0 if negative (sign bit set) before it drives o_res_data. When undefined, the raw signed sum passes through unchanged. Latch timing is identical in both cases.

Test Plan:
- VEC_LEN=4, NUM_NEURONS=2, MAC model latency 1, i_res_ready=1, start rise -> o_w_addr sequence 0,1,2,3 then 4,5,6,7. o_mac_clear high at addr 0 and 4. Two results with idx 0 and 1. o_done pulses once.
- Inputs all 1, weights neuron0 = {1,2,3,4}, neuron1 = {-5,-5,-5,-5} -> results 10 and -20. With FC_RELU_EN: 10 and 0.
- i_res_ready low 5 cycles on neuron0 -> o_res_valid and o_res_data=10 held stable. No neuron1 issue until the handshake completes.
- i_abort asserted during neuron1 ISSUE at k=2 -> IDLE next cycle, o_busy=0, no o_done. A following start rise runs a full clean sequence.
- i_start held high for 20 cycles and re-pulsed while busy -> exactly one run. Reset asserted mid-DRAIN -> all outputs 0 immediately.
- Default params (225x10), MAC latency 3 -> o_w_addr ends at 2249. Ten results returned, each latched on the 225th return.

Source files
------------

// File: rtl/fc_mac_scheduler.sv
// fc_mac_scheduler: time-multiplexes one accumulating MAC unit across the
// output neurons of a fully connected layer. It issues input/weight addresses
// one term per cycle, counts returned MAC results and presents one result per
// neuron on a valid/ready stream.
// Optional build macro: FC_RELU_EN clamps negative neuron results to zero.
module fc_mac_scheduler #(
  parameter int VEC_LEN     = 225,
  parameter int NUM_NEURONS = 10,
  parameter int ACC_W       = 48,
  parameter int MAC_LAT     = 1,
  localparam int IN_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
  localparam int WA_W  = (VEC_LEN * NUM_NEURONS > 1) ? $clog2(VEC_LEN * NUM_NEURONS) : 1,
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int R_W   = $clog2(VEC_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [IN_W-1:0]         o_in_addr,
  output logic [WA_W-1:0]         o_w_addr,
  output logic                    o_mac_valid,
  output logic                    o_mac_clear,
  input  logic                    i_mac_valid,
  input  logic signed [ACC_W-1:0] i_mac_sum,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic signed [ACC_W-1:0] o_res_data,
  output logic [IDX_W-1:0]        o_res_idx
);

  // The scheduler is independent of the MAC latency; it only counts returns.
  if (VEC_LEN < 1 || NUM_NEURONS < 1 || MAC_LAT < 0) begin : g_param_check
    $error("fc_mac_scheduler: invalid parameter values");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUTPUT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [IN_W-1:0]         k_q, k_d;
  logic [IDX_W-1:0]        n_q, n_d;
  logic [R_W-1:0]          r_q, r_d;
  logic                    start_d1_q, start_d1_d;
  logic                    start_armed_q, start_armed_d;
  logic signed [ACC_W-1:0] res_q, res_d;
  logic [IDX_W-1:0]        res_idx_q, res_idx_d;

  logic                    start_rise;
  logic                    last_issue;
  logic                    last_return;
  logic signed [ACC_W-1:0] latch_val;

  // A start level held through reset must go low once before an edge counts.
  assign start_rise  = i_start & ~start_d1_q & start_armed_q;
  assign last_issue  = (k_q == IN_W'(VEC_LEN - 1));
  assign last_return = i_mac_valid & (r_q == R_W'(VEC_LEN - 1));

`ifdef FC_RELU_EN
  assign latch_val = i_mac_sum[ACC_W-1] ? '0 : i_mac_sum;
`else
  assign latch_val = i_mac_sum;
`endif

  // State register and counters.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      n_q           <= '0;
      r_q           <= '0;
      start_d1_q    <= 1'b0;
      start_armed_q <= 1'b0;
      res_q         <= '0;
      res_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      n_q           <= n_d;
      r_q           <= r_d;
      start_d1_q    <= start_d1_d;
      start_armed_q <= start_armed_d;
      res_q         <= res_d;
      res_idx_q     <= res_idx_d;
    end
  end

  // Next-state, counter and result-latch logic; abort overrides everything.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    n_d           = n_q;
    r_d           = r_q;
    res_d         = res_q;
    res_idx_d     = res_idx_q;
    start_d1_d    = i_start;
    start_armed_d = start_armed_q | ~i_start;

    if (i_abort) begin
      state_d = S_IDLE;
      k_d     = '0;
      n_d     = '0;
      r_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            k_d     = '0;
            n_d     = '0;
            r_d     = '0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE, S_DRAIN: begin
          if (state_q == S_ISSUE) begin
            if (last_issue) begin
              k_d     = '0;
              state_d = S_DRAIN;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
          if (i_mac_valid) begin
            r_d = r_q + 1'b1;
          end
          // The final return wins over the issue-to-drain step (zero-latency MAC).
          if (last_return) begin
            res_d     = latch_val;
            res_idx_d = n_q;
            k_d       = '0;
            state_d   = S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (i_res_ready) begin
            r_d = '0;
            if (n_q == IDX_W'(NUM_NEURONS - 1)) begin
              state_d = S_DONE;
            end else begin
              n_d     = n_q + 1'b1;
              state_d = S_ISSUE;
            end
          end
        end
        S_DONE: begin
          n_d     = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_mac_valid = (state_q == S_ISSUE);
  assign o_mac_clear = (state_q == S_ISSUE) && (k_q == '0);
  assign o_in_addr   = k_q;
  assign o_w_addr    = WA_W'(n_q) * WA_W'(VEC_LEN) + WA_W'(k_q);
  assign o_res_valid = (state_q == S_OUTPUT);
  assign o_res_data  = res_q;
  assign o_res_idx   = res_idx_q;

endmodule

// File: tb/tb_fc_mac_scheduler.sv
// Self-checking bench for fc_mac_scheduler. Two instances: a small 4x2 layer
// with a latency-1 MAC for directed/random scenarios, and the default 225x10
// layer with a latency-3 MAC. Expected neuron results are plain dot products
// of the bench's input/weight arrays.
module tb_fc_mac_scheduler;
  localparam int SV = 4, SN = 2, AW = 48;
  localparam int BV = 225, BN = 10, BLAT = 3;
  localparam int S_IW = $clog2(SV), S_WW = $clog2(SV * SN), S_XW = $clog2(SN);
  localparam int B_IW = $clog2(BV), B_WW = $clog2(BV * BN), B_XW = $clog2(BN);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- small instance ----------------
  logic s_start = 1'b0, s_abort = 1'b0, s_ready = 1'b1;
  logic s_busy, s_done, s_mac_valid, s_mac_clear, s_res_valid, s_mv;
  logic [S_IW-1:0] s_in_addr;
  logic [S_WW-1:0] s_w_addr;
  logic [S_XW-1:0] s_res_idx;
  logic signed [AW-1:0] s_msum, s_res_data, s_acc, s_nxt;
  int s_in [SV];
  int s_w  [SV*SN];

  fc_mac_scheduler #(.VEC_LEN(SV), .NUM_NEURONS(SN), .ACC_W(AW), .MAC_LAT(1)) u_small (
    .clk(clk), .rst(rst), .i_start(s_start), .i_abort(s_abort),
    .o_busy(s_busy), .o_done(s_done), .o_in_addr(s_in_addr), .o_w_addr(s_w_addr),
    .o_mac_valid(s_mac_valid), .o_mac_clear(s_mac_clear),
    .i_mac_valid(s_mv), .i_mac_sum(s_msum),
    .o_res_valid(s_res_valid), .i_res_ready(s_ready),
    .o_res_data(s_res_data), .o_res_idx(s_res_idx)
  );

  // Latency-1 accumulating MAC for the small instance.
  always_comb s_nxt = (s_mac_clear ? AW'(0) : s_acc)
                    + AW'(longint'(s_in[s_in_addr]) * longint'(s_w[s_w_addr]));
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_mv <= 1'b0; s_msum <= '0; s_acc <= '0;
    end else begin
      s_mv <= s_mac_valid;
      s_msum <= s_nxt;
      if (s_mac_valid) s_acc <= s_nxt;
    end
  end

  // ---------------- big instance ----------------
  logic b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b1;
  logic b_busy, b_done, b_mac_valid, b_mac_clear, b_res_valid, b_mv;
  logic [B_IW-1:0] b_in_addr;
  logic [B_WW-1:0] b_w_addr;
  logic [B_XW-1:0] b_res_idx;
  logic signed [AW-1:0] b_msum, b_res_data, b_acc, b_nxt;
  logic [BLAT-1:0] b_vpipe;
  logic signed [AW-1:0] b_spipe [BLAT];
  int b_in [BV];
  int b_w  [BV*BN];

  fc_mac_scheduler #(.VEC_LEN(BV), .NUM_NEURONS(BN), .ACC_W(AW), .MAC_LAT(BLAT)) u_big (
    .clk(clk), .rst(rst), .i_start(b_start), .i_abort(b_abort),
    .o_busy(b_busy), .o_done(b_done), .o_in_addr(b_in_addr), .o_w_addr(b_w_addr),
    .o_mac_valid(b_mac_valid), .o_mac_clear(b_mac_clear),
    .i_mac_valid(b_mv), .i_mac_sum(b_msum),
    .o_res_valid(b_res_valid), .i_res_ready(b_ready),
    .o_res_data(b_res_data), .o_res_idx(b_res_idx)
  );

  // Latency-3 accumulating MAC for the big instance.
  always_comb b_nxt = (b_mac_clear ? AW'(0) : b_acc)
                    + AW'(longint'(b_in[b_in_addr]) * longint'(b_w[b_w_addr]));
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_vpipe <= '0; b_acc <= '0;
      for (int i = 0; i < BLAT; i++) b_spipe[i] <= '0;
    end else begin
      b_vpipe <= {b_vpipe[BLAT-2:0], b_mac_valid};
      b_spipe[0] <= b_nxt;
      for (int i = 1; i < BLAT; i++) b_spipe[i] <= b_spipe[i-1];
      if (b_mac_valid) b_acc <= b_nxt;
    end
  end
  assign b_mv   = b_vpipe[BLAT-1];
  assign b_msum = b_spipe[BLAT-1];

  // ---------------- reference model ----------------
  function automatic longint relu(input longint v);
`ifdef FC_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  function automatic longint calc_s(input int n);
    longint acc = 0;
    for (int k = 0; k < SV; k++) acc += longint'(s_in[k]) * longint'(s_w[n*SV + k]);
    return relu(acc);
  endfunction

  function automatic longint calc_b(input int n);
    longint acc = 0;
    for (int k = 0; k < BV; k++) acc += longint'(b_in[k]) * longint'(b_w[n*BV + k]);
    return relu(acc);
  endfunction

  // Small-instance per-cycle compare against the expected issue/result order.
  int s_issue = 0, s_acc_cnt = 0, s_done_cnt = 0, s_res_total = 0, s_issue_total = 0;
  logic s_hold = 1'b0;
  longint s_hold_data = 0, s_hold_idx = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (!s_busy) begin
        check("s_idle_quiet", {s_mac_valid, s_res_valid, s_done}, 0);
        s_issue = 0; s_acc_cnt = 0; s_hold = 1'b0;
      end else begin
        if (s_hold) begin
          check("s_hold_valid", s_res_valid, 1);
          check("s_hold_data", s_res_data, s_hold_data);
          check("s_hold_idx", s_res_idx, s_hold_idx);
        end
        if (s_mac_valid) begin
          check("s_w_addr", s_w_addr, s_issue);
          check("s_in_addr", s_in_addr, s_issue % SV);
          check("s_mac_clear", s_mac_clear, (s_issue % SV) == 0);
          check("s_no_overlap", s_issue / SV, s_acc_cnt);
          s_issue++; s_issue_total++;
        end
        if (s_res_valid) begin
          check("s_res_idx", s_res_idx, s_acc_cnt);
          check("s_res_data", s_res_data, calc_s(s_acc_cnt));
          check("s_res_after_issue", s_issue, (s_acc_cnt + 1) * SV);
          check("s_res_mac_idle", s_mac_valid, 0);
          s_hold = !s_ready; s_hold_data = s_res_data; s_hold_idx = s_res_idx;
          if (s_ready) begin s_acc_cnt++; s_res_total++; end
        end else begin
          s_hold = 1'b0;
        end
        if (s_done) begin
          check("s_done_after_all", s_acc_cnt, SN);
          s_done_cnt++;
        end
      end
    end
  end

  // Big-instance per-cycle compare.
  int b_issue = 0, b_acc_cnt = 0, b_done_cnt = 0, b_res_total = 0, b_issue_total = 0;
  longint b_last_waddr = -1;
  always @(negedge clk) begin
    if (rst) begin
      if (!b_busy) begin
        b_issue = 0; b_acc_cnt = 0;
      end else begin
        if (b_mac_valid) begin
          check("b_w_addr", b_w_addr, b_issue);
          b_last_waddr = b_w_addr; b_issue++; b_issue_total++;
        end
        if (b_res_valid) begin
          check("b_res_idx", b_res_idx, b_acc_cnt);
          check("b_res_data", b_res_data, calc_b(b_acc_cnt));
          check("b_res_after_issue", b_issue, (b_acc_cnt + 1) * BV);
          if (b_ready) begin b_acc_cnt++; b_res_total++; end
        end
        if (b_done) b_done_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic s_pulse_start();
    s_start = 1'b1; tick(); s_start = 1'b0;
  endtask

  task automatic wait_s_done(input int budget);
    int d0 = s_done_cnt;
    int c = 0;
    while (s_done_cnt == d0 && c < budget) begin tick(); c++; end
    check("s_done_within_budget", s_done_cnt - d0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, i0, c;
    longint exp1;
    for (int k = 0; k < SV; k++) s_in[k] = 1;
    for (int k = 0; k < SV*SN; k++) s_w[k] = 0;
    for (int k = 0; k < BV; k++) b_in[k] = int'($urandom_range(0, 200)) - 100;
    for (int k = 0; k < BV*BN; k++) b_w[k] = int'($urandom_range(0, 200)) - 100;

    // Reset state
    tick(3);
    check("rst_small_outputs", {s_busy, s_done, s_mac_valid, s_mac_clear, s_res_valid,
                                s_in_addr, s_w_addr, s_res_idx, s_res_data}, 0);
    check("rst_big_ctrl", {b_busy, b_done, b_mac_valid, b_mac_clear, b_res_valid,
                           b_in_addr, b_w_addr, b_res_idx}, 0);
    check("rst_big_data", b_res_data, 0);
    rst = 1'b1;
    tick(2);

    // Default-size layer, MAC latency 3
    b_start = 1'b1; tick(); b_start = 1'b0;
    c = 0;
    while (b_done_cnt == 0 && c < 4000) begin tick(); c++; end
    check("b_done_once", b_done_cnt, 1);
    check("b_last_waddr", b_last_waddr, BV*BN - 1);
    check("b_results", b_res_total, BN);
    check("b_issues", b_issue_total, BV*BN);

    // Directed small run: inputs 1, weights {1,2,3,4} and {-5,-5,-5,-5}
    s_w[0] = 1; s_w[1] = 2; s_w[2] = 3; s_w[3] = 4;
    for (int k = 4; k < 8; k++) s_w[k] = -5;
`ifdef FC_RELU_EN
    exp1 = 0;
`else
    exp1 = -20;
`endif
    check("model_neuron0", calc_s(0), 10);
    check("model_neuron1", calc_s(1), exp1);
    d0 = s_done_cnt; r0 = s_res_total; i0 = s_issue_total;
    s_pulse_start();
    wait_s_done(100);
    check("dir_results", s_res_total - r0, SN);
    check("dir_issues", s_issue_total - i0, SV*SN);
    tick(3);
    check("dir_done_once", s_done_cnt - d0, 1);

    // Backpressure on neuron 0 for 5 cycles
    s_ready = 1'b0;
    s_pulse_start();
    c = 0;
    while (!s_res_valid && c < 100) begin tick(); c++; end
    check("bp_valid_seen", s_res_valid, 1);
    repeat (5) begin
      check("bp_data", s_res_data, 10);
      check("bp_mac_idle", s_mac_valid, 0);
      tick();
    end
    s_ready = 1'b1;
    wait_s_done(100);

    // Abort during neuron 1 issue at k=2
    tick(2);
    d0 = s_done_cnt;
    s_pulse_start();
    c = 0;
    while (!(s_mac_valid && s_w_addr == S_WW'(SV + 2)) && c < 100) begin tick(); c++; end
    check("abort_point_seen", s_w_addr, SV + 2);
    s_abort = 1'b1; tick(); s_abort = 1'b0;
    check("abort_busy", s_busy, 0);
    check("abort_outs", {s_mac_valid, s_res_valid, s_done}, 0);
    tick(10);
    check("abort_no_done", s_done_cnt - d0, 0);
    r0 = s_res_total;
    s_pulse_start();
    wait_s_done(100);
    check("abort_clean_rerun", s_res_total - r0, SN);

    // Start held high for 20 cycles: exactly one run
    tick(2);
    d0 = s_done_cnt;
    s_start = 1'b1; tick(20); s_start = 1'b0; tick(5);
    check("held_start_one_run", s_done_cnt - d0, 1);
    check("held_start_idle", s_busy, 0);

    // Re-pulse while busy: ignored
    d0 = s_done_cnt;
    s_start = 1'b1; tick(2); s_start = 1'b0; tick(2);
    s_start = 1'b1; tick(2); s_start = 1'b0;
    wait_s_done(100);
    tick(5);
    check("repulse_one_run", s_done_cnt - d0, 1);
    check("repulse_idle", s_busy, 0);

    // Reset mid-DRAIN with start held high through reset
    s_pulse_start();
    c = 0;
    while (!(s_busy && !s_mac_valid && !s_res_valid && !s_done) && c < 100) begin tick(); c++; end
    check("drain_seen", s_busy, 1);
    s_start = 1'b1;
    rst = 1'b0;
    #1;
    check("rst_mid_drain", {s_busy, s_done, s_mac_valid, s_mac_clear, s_res_valid,
                            s_in_addr, s_w_addr, s_res_idx, s_res_data}, 0);
    tick(3);
    rst = 1'b1;
    tick(5);
    check("held_start_after_reset", s_busy, 0);
    s_start = 1'b0; tick();
    s_start = 1'b1; tick();
    check("launch_after_low", s_busy, 1);
    s_start = 1'b0;
    wait_s_done(100);

    // Random data with random backpressure
    for (int run = 0; run < 8; run++) begin
      tick(2);
      for (int k = 0; k < SV; k++) s_in[k] = int'($urandom_range(0, 65535)) - 32768;
      for (int k = 0; k < SV*SN; k++) s_w[k] = int'($urandom_range(0, 65535)) - 32768;
      d0 = s_done_cnt; r0 = s_res_total;
      s_pulse_start();
      c = 0;
      while (s_done_cnt == d0 && c < 500) begin
        s_ready = ($urandom_range(0, 3) != 0);
        tick(); c++;
      end
      s_ready = 1'b1;
      check("rand_done", s_done_cnt - d0, 1);
      check("rand_results", s_res_total - r0, SN);
    end

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
